// File: rtl/wb_bram_slave.sv
// wb_bram_slave
// Wishbone classic slave in front of an inferred single-port block RAM.
// Each transfer is terminated by a one-cycle ACK_O, or by a one-cycle ERR_O
// when the address is past the last word.
//
// Ports
//   CLK_I        clock, rising edge
//   RST_I        asynchronous active-high reset
//   CYC_I/STB_I  bus cycle / strobe; a request is CYC_I & STB_I
//   WE_I         1 = write, 0 = read
//   ADR_I        word address (AW bits)
//   SEL_I        byte-lane write enables (DW/8 bits)
//   DAT_I        write data
//   DAT_O        registered read data; changes only when a read completes
//   ACK_O        registered normal termination pulse
//   ERR_O        registered error termination pulse
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request; the only state that samples the bus
// RD_WAIT | read accepted, waiting out the extra latency cycle(s)
// RESP    | termination pulse is on ACK_O or ERR_O; back to IDLE next

module wb_bram_slave #(
    parameter int DW     = 32,
    parameter int AW     = 3,
    parameter int DEPTH  = 8,
    parameter int RD_LAT = 1
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic            CYC_I,
    input  logic            STB_I,
    input  logic            WE_I,
    input  logic [AW-1:0]   ADR_I,
    input  logic [DW/8-1:0] SEL_I,
    input  logic [DW-1:0]   DAT_I,
    output logic [DW-1:0]   DAT_O,
    output logic            ACK_O,
    output logic            ERR_O
);

    localparam int NB = DW / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH widened by one bit so the range compare works even when
    // DEPTH == 2**AW (then every address is in range).
    localparam logic [AW:0] DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [1:0]  LAT_LOAD = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [DW-1:0]   pipe_q, pipe_d;
    logic [1:0]      cnt_q, cnt_d;

    logic            req;
    logic            in_range;
    logic [IW-1:0]   idx;
    logic            mem_wr_en;
    logic [DW-1:0]   mem_rd;

    logic [DW-1:0]   mem_q [DEPTH];

    assign req      = CYC_I & STB_I;
    assign in_range = ({1'b0, ADR_I} < DEPTH_W);
    assign idx      = ADR_I[IW-1:0];
    assign mem_rd   = mem_q[idx];

    // Storage: not reset. Writes are suppressed while reset is held so a
    // request present during reset cannot slip into the array.
    always_ff @(posedge CLK_I) begin
        if (mem_wr_en && !RST_I) begin
            for (int i = 0; i < NB; i++) begin
                if (SEL_I[i]) begin
                    mem_q[idx][8*i +: 8] <= DAT_I[8*i +: 8];
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            pipe_q  <= '0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            pipe_q  <= pipe_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!in_range || WE_I) begin
                        state_d = RESP;
                    end else if (RD_LAT == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // Only CYC_I matters here: STB_I/ADR_I were consumed at accept.
                if (!CYC_I) begin
                    state_d = IDLE;
                end else if (cnt_q <= 2'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_d     = dat_q;
        pipe_d    = pipe_q;
        cnt_d     = cnt_q;
        mem_wr_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (WE_I) begin
                        mem_wr_en = 1'b1;
                        ack_d     = 1'b1;
                    end else begin
                        cnt_d = LAT_LOAD;
                        if (RD_LAT == 1) begin
                            dat_d = mem_rd;
                            ack_d = 1'b1;
                        end else begin
                            // Capture the word now so later bus changes
                            // cannot affect what this read returns.
                            pipe_d = mem_rd;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (!CYC_I) begin
                    cnt_d = 2'd0;
                end else if (cnt_q <= 2'd1) begin
                    cnt_d = 2'd0;
                    dat_d = pipe_q;
                    ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
            end
        endcase
    end

    assign DAT_O = dat_q;
    assign ACK_O = ack_q;
    assign ERR_O = err_q;

endmodule

// File: tb/tb_wb_bram_slave.sv
module tb_wb_bram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Main instance: DW=32 AW=4 DEPTH=12 RD_LAT=2
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  adr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        ack, err;

    // Second instance: RD_LAT=1, DEPTH=16 (full address space)
    logic        c1_cyc = 1'b0, c1_stb = 1'b0, c1_we = 1'b0;
    logic [3:0]  c1_adr = '0;
    logic [3:0]  c1_sel = '0;
    logic [31:0] c1_dat_i = '0;
    logic [31:0] c1_dat_o;
    logic        c1_ack, c1_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_mem [12];
    logic [31:0] ref_dat;
    logic [31:0] m1 [16];

    always #5 clk = ~clk;

    wb_bram_slave #(.DW(32), .AW(4), .DEPTH(12), .RD_LAT(2)) dut (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
        .ADR_I(adr), .SEL_I(sel), .DAT_I(dat_i),
        .DAT_O(dat_o), .ACK_O(ack), .ERR_O(err)
    );

    wb_bram_slave #(.DW(32), .AW(4), .DEPTH(16), .RD_LAT(1)) dut1 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(c1_cyc), .STB_I(c1_stb), .WE_I(c1_we),
        .ADR_I(c1_adr), .SEL_I(c1_sel), .DAT_I(c1_dat_i),
        .DAT_O(c1_dat_o), .ACK_O(c1_ack), .ERR_O(c1_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ACK and ERR must never coincide on either instance
    always @(negedge clk) begin
        if (!rst) begin
            chk("ack_err_excl", {31'd0, ack & err}, 32'd0);
            chk("c1_ack_err_excl", {31'd0, c1_ack & c1_err}, 32'd0);
        end
    end

    // One complete transfer on the main instance, starting and ending in IDLE.
    task automatic xfer(input bit w, input logic [3:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit abort);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        tick;                                   // accept edge
        stb = 1'b0;                             // scramble bus after accept
        adr = 4'($urandom); sel = 4'($urandom); dat_i = $urandom;
        if (a >= 4'd12) begin
            cyc = 1'b0;
            chk("err_pulse", {31'd0, err}, 32'd1);
            chk("err_no_ack", {31'd0, ack}, 32'd0);
            chk("err_dat_hold", dat_o, ref_dat);
            tick;
            chk("err_one_cycle", {31'd0, err}, 32'd0);
        end else if (w) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
            cyc = 1'b0;
            chk("wr_ack", {31'd0, ack}, 32'd1);
            chk("wr_no_err", {31'd0, err}, 32'd0);
            chk("wr_dat_hold", dat_o, ref_dat);
            tick;
            chk("wr_ack_one_cycle", {31'd0, ack}, 32'd0);
        end else begin
            chk("rd_wait_no_ack", {31'd0, ack | err}, 32'd0);
            chk("rd_wait_dat_hold", dat_o, ref_dat);
            if (abort) begin
                cyc = 1'b0;
                tick;
                chk("abort_no_ack", {31'd0, ack}, 32'd0);
                chk("abort_dat_hold", dat_o, ref_dat);
                tick;
                chk("abort_no_late_ack", {31'd0, ack}, 32'd0);
            end else begin
                tick;
                ref_dat = ref_mem[a];
                cyc = 1'b0;
                chk("rd_ack", {31'd0, ack}, 32'd1);
                chk("rd_no_err", {31'd0, err}, 32'd0);
                chk("rd_data", dat_o, ref_dat);
                tick;
                chk("rd_ack_one_cycle", {31'd0, ack}, 32'd0);
                chk("rd_dat_hold", dat_o, ref_dat);
            end
        end
    endtask

    initial begin
        logic [3:0]  a;
        logic [31:0] d;
        bit          w;
        int          nack;
        logic [3:0]  la [4];

        ref_dat = '0;
        for (int i = 0; i < 12; i++) ref_mem[i] = '0;

        // Reset state
        repeat (3) tick;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        rst = 1'b0;

        // Fill every in-range word so later random reads are defined
        for (int i = 0; i < 12; i++) xfer(1'b1, 4'(i), 4'hF, $urandom, 1'b0);

        // Write then read back full word
        xfer(1'b1, 4'd3, 4'hF, 32'hDEADBEEF, 1'b0);
        xfer(1'b0, 4'd3, 4'h0, 32'h0, 1'b0);
        chk("raw_deadbeef", dat_o, 32'hDEADBEEF);

        // Byte-lane merge
        xfer(1'b1, 4'd5, 4'hF, 32'h11223344, 1'b0);
        xfer(1'b1, 4'd5, 4'h5, 32'hAABBCCDD, 1'b0);
        xfer(1'b0, 4'd5, 4'hF, 32'h0, 1'b0);
        chk("lane_merge", dat_o, 32'h11BB33DD);

        // SEL = 0 write changes nothing
        xfer(1'b1, 4'd5, 4'h0, 32'hFFFFFFFF, 1'b0);
        xfer(1'b0, 4'd5, 4'h0, 32'h0, 1'b0);
        chk("sel0_no_change", dat_o, 32'h11BB33DD);

        // Out-of-range accesses
        xfer(1'b0, 4'd12, 4'hF, 32'h0, 1'b0);
        xfer(1'b1, 4'd12, 4'hF, 32'hCAFEF00D, 1'b0);
        xfer(1'b1, 4'd15, 4'hF, 32'hCAFEF00D, 1'b0);
        xfer(1'b0, 4'd15, 4'hF, 32'h0, 1'b0);
        chk("oor_dat_hold", dat_o, 32'h11BB33DD);

        // Abort in RD_WAIT, then a normal read
        xfer(1'b0, 4'd3, 4'hF, 32'h0, 1'b1);
        chk("abort_keeps_dat", dat_o, 32'h11BB33DD);
        xfer(1'b0, 4'd3, 4'hF, 32'h0, 1'b0);
        chk("after_abort_read", dat_o, 32'hDEADBEEF);

        // Reset asserted asynchronously during RD_WAIT
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd5;
        tick;
        stb = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_dat", dat_o, 32'd0);
        chk("async_rst_ack", {31'd0, ack}, 32'd0);
        chk("async_rst_err", {31'd0, err}, 32'd0);
        cyc = 1'b0;
        ref_dat = '0;
        tick;
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("post_rst_no_ack", {31'd0, ack}, 32'd0);
            chk("post_rst_dat", dat_o, 32'd0);
        end
        xfer(1'b0, 4'd5, 4'hF, 32'h0, 1'b0);
        chk("mem_kept_over_rst", dat_o, 32'h11BB33DD);

        // Randomized transfers against the reference model
        for (int n = 0; n < 60; n++) begin
            a = 4'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            xfer(w, a, 4'($urandom), d, (!w) && ($urandom_range(0, 4) == 0));
        end

        // RD_LAT=1 instance: request held continuously, one transfer per 2 cycles
        la[0] = 4'd13; la[1] = 4'd14; la[2] = 4'd15; la[3] = 4'd2;
        for (int pass = 0; pass < 2; pass++) begin
            int k;
            k = 0; nack = 0;
            c1_cyc = 1'b1; c1_stb = 1'b1; c1_we = (pass == 0); c1_sel = 4'hF;
            c1_adr = la[0]; c1_dat_i = $urandom;
            for (int i = 0; i < 8; i++) begin
                tick;
                chk("c1_no_err", {31'd0, c1_err}, 32'd0);
                chk("c1_ack_cadence", {31'd0, c1_ack}, {31'd0, (i % 2) == 0});
                if (c1_ack) nack++;
                if ((i % 2) == 0 && k < 4) begin
                    if (pass == 0) m1[la[k]] = c1_dat_i;
                    else chk("c1_rd_data", c1_dat_o, m1[la[k]]);
                    k++;
                    if (k < 4) begin
                        c1_adr = la[k]; c1_dat_i = $urandom;
                    end else begin
                        c1_cyc = 1'b0; c1_stb = 1'b0;
                    end
                end
            end
            chk("c1_ack_total", nack, 32'd4);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
